// File: rtl/fir_out_capture.sv
// Hardware capture of one FIR output burst: buffers samples in a FWFT FIFO,
// tracks burst start/end and overflow, and serves them to a valid/ready reader.
module fir_out_capture #(
    parameter int DATA_INTE_WL = 4,
    parameter int DATA_FRAC_WL = 12,
    parameter int DEPTH        = 64,
    parameter int CNT_WL       = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   clear,
    input  logic                                   in_valid,
    input  logic signed [DATA_INTE_WL+DATA_FRAC_WL-1:0] data_in,
    output logic                                   rd_valid,
    input  logic                                   rd_ready,
    output logic signed [DATA_INTE_WL+DATA_FRAC_WL-1:0] rd_data,
    output logic                                   rd_last,
    output logic                                   burst_done,
    output logic                                   overflow,
    output logic [CNT_WL-1:0]                      sample_count
);

    localparam int DW = DATA_INTE_WL + DATA_FRAC_WL;
    localparam int AW = $clog2(DEPTH);

    localparam logic [AW-1:0]     PTR_ONE  = AW'(1);
    localparam logic [AW:0]       OCC_ONE  = (AW+1)'(1);
    localparam logic [AW:0]       OCC_FULL = (AW+1)'(DEPTH);
    localparam logic [CNT_WL-1:0] CNT_ONE  = CNT_WL'(1);
    localparam logic [CNT_WL-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        occ_q, occ_d;
    logic               overflow_q, overflow_d;
    logic [CNT_WL-1:0]  count_q, count_d;
    logic signed [DW-1:0] mem_q [DEPTH];

    logic full, empty, pop, wr_en, pop_en;

    assign full   = (occ_q == OCC_FULL);
    assign empty  = (occ_q == '0);
    assign pop    = rd_valid && rd_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en  = in_valid && (state_q != DONE) && (!full || pop) && !clear;
    assign pop_en = pop && !clear;

    assign rd_valid     = !empty;
    assign rd_data      = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign overflow     = overflow_q;
    assign sample_count = count_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so every register
        // samples the pre-edge values regardless of process ordering.
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (in_valid) state_d = CAPTURE;
                CAPTURE: if (!in_valid) state_d = DONE;
                DONE:    if (empty || (pop && occ_q == OCC_ONE)) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        burst_done = (state_q == DONE);
        rd_last    = rd_valid && (state_q == DONE) && (occ_q == OCC_ONE);
    end

    // ---------------- FIFO pointers, occupancy, flags ----------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        overflow_d = overflow_q;
        count_d    = count_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            occ_d      = '0;
            overflow_d = 1'b0;
            count_d    = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by plain overflow.
            if (wr_en)  wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
            unique case ({wr_en, pop_en})
                2'b10:   occ_d = occ_q + OCC_ONE;
                2'b01:   occ_d = occ_q - OCC_ONE;
                default: occ_d = occ_q;
            endcase
            if (in_valid && !wr_en) overflow_d = 1'b1;
            if (wr_en) begin
                if (state_q == IDLE)       count_d = CNT_ONE;
                else if (count_q != CNT_MAX) count_d = count_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
            count_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; empty pointers/occupancy make
    // stale contents unobservable, and rd_data is forced to 0 when empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= data_in;
    end

endmodule

// File: tb/tb_fir_out_capture.sv
// Directed bench for fir_out_capture: stimulus pushes expected samples into a
// queue, an independent monitor pops and compares on every reader handshake.
module tb_fir_out_capture;

    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    last;   // 0: rd_last low, 1: rd_last high, 2: not checked
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          in_valid;
    logic [DW-1:0] data_in;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          burst_done;
    logic          overflow;
    logic [15:0]   sample_count;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] t1_data [5] = '{16'h0100, 16'hFF00, 16'h7FFF, 16'h8000, 16'h0001};
    logic [DW-1:0] bp_data [8] = '{16'h1234, 16'h2345, 16'h3456, 16'h4567,
                                   16'h5678, 16'h6789, 16'h789A, 16'h89AB};

    always #5 clk = ~clk;

    fir_out_capture #(
        .DATA_INTE_WL(4),
        .DATA_FRAC_WL(12),
        .DEPTH(64),
        .CNT_WL(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .in_valid(in_valid),
        .data_in(data_in),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .rd_data(rd_data),
        .rd_last(rd_last),
        .burst_done(burst_done),
        .overflow(overflow),
        .sample_count(sample_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit push, input logic [1:0] last);
        in_valid = 1'b1;
        data_in  = d;
        if (push) exp_q.push_back('{data: d, last: last});
        tick();
    endtask

    task automatic end_burst();
        in_valid = 1'b0;
        data_in  = '0;
        tick();
    endtask

    task automatic do_clear();
        in_valid = 1'b0;
        clear    = 1'b1;
        tick();
        exp_q.delete();
        clear    = 1'b0;
    endtask

    task automatic drain(input bit pattern, input int start);
        int c = start;
        int budget = 400;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && budget > 0) begin
            rd_ready = pattern ? (c % 3 == 0) : 1'b1;
            tick();
            c++;
            budget--;
        end
        check("drain_complete", 32'(exp_q.size()), 0);
        rd_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_valid"},     32'(rd_valid), 0);
        check({tag, "_rd_data"},      32'(rd_data), 0);
        check({tag, "_rd_last"},      32'(rd_last), 0);
        check({tag, "_burst_done"},   32'(burst_done), 0);
        check({tag, "_overflow"},     32'(overflow), 0);
        check({tag, "_sample_count"}, 32'(sample_count), 0);
    endtask

    // Monitor: head must match the scoreboard whenever valid (also while
    // stalled); rd_last is judged on the popping cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sample", 32'(rd_data), 32'hDEAD_BEEF);
                end else begin
                    check("rd_data", 32'(rd_data), 32'(exp_q[0].data));
                    if (rd_ready) begin
                        if (exp_q[0].last != 2'd2)
                            check("rd_last", 32'(rd_last), 32'(exp_q[0].last));
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                check("idle_rd_data_zero", 32'(rd_data), 0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;
        rd_ready = 1'b0;
        repeat (3) tick();
        check_reset_outputs("por");
        rst = 1'b1;
        tick();

        // Basic burst, free reader. The last sample leaves on the burst-end
        // edge, before DONE is entered, so its rd_last is not judged here.
        rd_ready = 1'b1;
        for (int i = 0; i < 5; i++)
            send(t1_data[i], 1'b1, (i == 4) ? 2'd2 : 2'd0);
        end_burst();
        check("t1_burst_done", 32'(burst_done), 1);
        check("t1_sample_count", 32'(sample_count), 5);
        check("t1_fifo_empty", 32'(rd_valid), 0);
        tick();
        check("t1_back_to_idle", 32'(burst_done), 0);
        check("t1_count_hold", 32'(sample_count), 5);
        check("t1_all_read", 32'(exp_q.size()), 0);
        rd_ready = 1'b0;

        // Overflow: 70-sample ramp into a 64-deep FIFO with a stalled reader.
        do_clear();
        for (int i = 0; i < 70; i++)
            send(16'(i), i < 64, (i == 63) ? 2'd1 : 2'd0);
        end_burst();
        check("ovf_overflow", 32'(overflow), 1);
        check("ovf_sample_count", 32'(sample_count), 64);
        check("ovf_burst_done", 32'(burst_done), 1);
        drain(1'b0, 0);
        check("ovf_idle_after_drain", 32'(burst_done), 0);
        check("ovf_sticky", 32'(overflow), 1);

        // Full FIFO, then push and pop together for 10 more samples.
        do_clear();
        check("clear_overflow", 32'(overflow), 0);
        check("clear_count", 32'(sample_count), 0);
        for (int i = 0; i < 64; i++)
            send(16'(100 + i), 1'b1, 2'd0);
        rd_ready = 1'b1;
        for (int i = 64; i < 74; i++)
            send(16'(100 + i), 1'b1, (i == 73) ? 2'd1 : 2'd0);
        end_burst();
        check("full_no_overflow", 32'(overflow), 0);
        check("full_sample_count", 32'(sample_count), 74);
        drain(1'b0, 0);
        check("full_idle_after_drain", 32'(burst_done), 0);

        // Reader backpressure with rd_ready 1,0,0,1,0,0...
        do_clear();
        for (int i = 0; i < 8; i++) begin
            rd_ready = (i % 3 == 0);
            send(bp_data[i], 1'b1, (i == 7) ? 2'd1 : 2'd0);
        end
        rd_ready = 1'b0;
        end_burst();
        check("bp_burst_done", 32'(burst_done), 1);
        check("bp_sample_count", 32'(sample_count), 8);
        drain(1'b1, 9);
        check("bp_overflow", 32'(overflow), 0);

        // Samples arriving during DONE are dropped; bursts do not merge.
        do_clear();
        for (int i = 0; i < 4; i++)
            send(16'hA000 + 16'(i), 1'b1, (i == 3) ? 2'd1 : 2'd0);
        end_burst();
        send(16'hBEEF, 1'b0, 2'd0);
        send(16'hCAFE, 1'b0, 2'd0);
        end_burst();
        check("done_overflow", 32'(overflow), 1);
        check("done_sample_count", 32'(sample_count), 4);
        check("done_burst_done", 32'(burst_done), 1);
        drain(1'b0, 0);
        tick();
        check("done_exactly_four", 32'(rd_valid), 0);
        check("done_idle", 32'(burst_done), 0);

        // Reset mid-burst (overflow is still set from the previous case).
        for (int i = 0; i < 3; i++)
            send(16'h0C00 + 16'(i), 1'b1, 2'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("rst_async");
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("rst_release");

        // Clear after sample 3 of 6: the remaining 3 form a new burst.
        for (int i = 0; i < 3; i++)
            send(16'h0D00 + 16'(i), 1'b1, 2'd0);
        check("clr_pre_count", 32'(sample_count), 3);
        do_clear();
        check("clr_count_zero", 32'(sample_count), 0);
        check("clr_fifo_empty", 32'(rd_valid), 0);
        for (int i = 3; i < 6; i++)
            send(16'h0D00 + 16'(i), 1'b1, (i == 5) ? 2'd1 : 2'd0);
        end_burst();
        check("clr_new_count", 32'(sample_count), 3);
        check("clr_burst_done", 32'(burst_done), 1);
        check("clr_overflow", 32'(overflow), 0);
        drain(1'b0, 0);

        repeat (3) tick();
        check("final_queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
